// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch (I) and data (D) ports.
// Optional macro DATA_PRIORITY_EN: D wins every tie instead of round-robin.
module unified_mem_arbiter #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_LEN-1:0] i_addr,
  output logic [DATA_LEN-1:0] i_rdata,
  output logic                i_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_LEN-1:0] d_addr,
  input  logic [DATA_LEN-1:0] d_wdata,
  output logic [DATA_LEN-1:0] d_rdata,
  output logic                d_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  input  logic [DATA_LEN-1:0] mem_rdata,
  input  logic                mem_ready,
  output logic                bus_err
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              WD_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // 1 = D was granted last
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_LEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_LEN-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_LEN-1:0] d_rdata_q, d_rdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic                bus_err_q, bus_err_d;
  logic                i_elig, d_elig, pick_d, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    bus_err_d    = 1'b0;
    busy_d       = (state_q == BUSY_D);

    // A port still showing its ready pulse is masked so a held req is not re-served.
    i_elig = i_req && !i_ready_q;
    d_elig = d_req && !d_ready_q;
`ifdef DATA_PRIORITY_EN
    pick_d = d_elig;
`else
    pick_d = d_elig && (!i_elig || !last_grant_q);
`endif

    case (state_q)
      IDLE: begin
        if (i_elig || d_elig) begin
          mem_req_d = 1'b1;
          cnt_d     = '0;
          if (pick_d) begin
            state_d      = BUSY_D;
            mem_we_d     = d_we;
            mem_addr_d   = d_addr;
            mem_wdata_d  = d_wdata;
            last_grant_d = 1'b1;
          end else begin
            state_d      = BUSY_I;
            mem_we_d     = 1'b0;
            mem_addr_d   = i_addr;
            last_grant_d = 1'b0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
          if (busy_d) begin
            d_ready_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else if (WD_EN && (cnt_q == CNT_LAST)) begin
          // Watchdog abort: complete the access with an error and a zero result.
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
          if (busy_d) begin
            d_ready_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = '0;
          end
        end else if (WD_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_rdata   = i_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = bus_err_q;

endmodule
